// File: rtl/iir_sched_pkg.sv
// Shared types, coefficients and fixed-point helper
// for the time-multiplexed de-emphasis IIR engine.
package iir_sched_pkg;

  localparam int C_DATA_WIDTH   = 32;
  localparam int C_TAP_COUNT    = 2;
  localparam int C_FB_TAP_COUNT = 2;
  localparam int C_QUANT_BITS   = 10;
  localparam int C_NUM_CH       = 2;

  typedef enum logic [1:0] {
    IDLE,
    MAC_X,
    MAC_Y,
    WRITE
  } state_e;

  typedef logic signed [C_DATA_WIDTH-1:0] coef_t;

  // Feed-forward weights, index i weights x[n-i]
  localparam coef_t X_COEFFS [C_TAP_COUNT] = '{
    32'sh0000_00B2,
    32'sh0000_00B2
  };

  // Feedback weights, index j weights y[n-1-j];
  // the subtraction is folded into the sign
  localparam coef_t Y_COEFFS [C_FB_TAP_COUNT] = '{
    32'shFFFF_FD66,
    32'sh0000_0000
  };

  // Full-width signed product, floor shift, wrap
  function automatic coef_t deq(
    input coef_t a,
    input coef_t b,
    input int    qbits
  );
    logic signed [2*C_DATA_WIDTH-1:0] p;
    p = $signed({{C_DATA_WIDTH{a[C_DATA_WIDTH-1]}}, a})
      * $signed({{C_DATA_WIDTH{b[C_DATA_WIDTH-1]}}, b});
    p = p >>> qbits;
    return C_DATA_WIDTH'(p);
  endfunction

endpackage

// File: rtl/iir_channel_scheduler_if.sv
// Per-channel sample in / result out handshake bundle
// between stereo demux, filter engine and output FIFOs.
interface iir_channel_scheduler_if
  import iir_sched_pkg::*;
#(
  parameter int NUM_CH     = C_NUM_CH,
  parameter int DATA_WIDTH = C_DATA_WIDTH
);

  logic [NUM_CH-1:0]                 in_valid;
  logic [NUM_CH-1:0]                 in_ready;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]                 out_valid;
  logic [NUM_CH-1:0]                 out_ready;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/iir_channel_scheduler_rr_arbiter.sv
// Combinational round-robin picker: search starts
// one past the last granted channel, one-hot result.
module rr_arbiter
  import iir_sched_pkg::*;
#(
  parameter int NUM_CH = C_NUM_CH,
  parameter int CW     = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     last_grant,
  output logic [NUM_CH-1:0] grant
);

  logic [CW-1:0] cand;
  logic          found;

  // first requester in rotated order wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CW'((int'(last_grant) + k) % NUM_CH);
      if (!found && req[cand]) begin
        grant[cand] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iir_channel_scheduler.sv
// Shared-MAC IIR engine: one channel per sample,
// one multiply per cycle, per-channel histories.
module iir_channel_scheduler
  import iir_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = C_DATA_WIDTH,
  parameter int TAP_COUNT    = C_TAP_COUNT,
  parameter int FB_TAP_COUNT = C_FB_TAP_COUNT,
  parameter int QUANT_BITS   = C_QUANT_BITS,
  parameter int NUM_CH       = C_NUM_CH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  iir_channel_scheduler_if.slave bus,
  output logic             busy
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int MT = (TAP_COUNT > FB_TAP_COUNT)
                    ? TAP_COUNT : FB_TAP_COUNT;
  localparam int IW = (MT > 1) ? $clog2(MT) : 1;

  typedef logic signed [DATA_WIDTH-1:0] word_t;

  state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  word_t    acc_q, acc_d;
  logic [CW-1:0] gnt_q, gnt_d;
  logic [CW-1:0] last_q, last_d;

  word_t xh_q [NUM_CH][TAP_COUNT];
  word_t xh_d [NUM_CH][TAP_COUNT];
  word_t yh_q [NUM_CH][FB_TAP_COUNT];
  word_t yh_d [NUM_CH][FB_TAP_COUNT];

  logic [NUM_CH-1:0] ov_q, ov_d;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0] od_q, od_d;

  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] grant;
  logic [CW-1:0]     gsel;

  // a channel holding an unread result sits out
  assign elig = bus.in_valid & ~ov_q;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CW     (CW)
  ) u_arb (
    .req        (elig),
    .last_grant (last_q),
    .grant      (grant)
  );

  // one-hot grant to channel index
  always_comb begin
    gsel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) gsel = CW'(c);
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;

  // scheduler FSM, MAC datapath and history update
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    xh_d         = xh_q;
    yh_d         = yh_q;
    ov_d         = ov_q & ~bus.out_ready;
    od_d         = od_q;
    bus.in_ready = '0;
    if (flush) begin
      state_d = IDLE;
      xh_d    = '{default: '0};
      yh_d    = '{default: '0};
      ov_d    = '0;
      od_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          bus.in_ready = reset ? '0 : grant;
          if (|grant) begin
            for (int t = TAP_COUNT - 1; t > 0; t--) begin
              xh_d[gsel][t] = xh_q[gsel][t-1];
            end
            xh_d[gsel][0] = bus.in_data[gsel];
            acc_d   = '0;
            idx_d   = '0;
            gnt_d   = gsel;
            last_d  = gsel;
            state_d = MAC_X;
          end
        end
        MAC_X: begin
          acc_d = acc_q + deq(xh_q[gnt_q][idx_q],
                              X_COEFFS[idx_q],
                              QUANT_BITS);
          if (idx_q == IW'(TAP_COUNT - 1)) begin
            idx_d   = '0;
            state_d = MAC_Y;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        MAC_Y: begin
          acc_d = acc_q + deq(yh_q[gnt_q][idx_q],
                              Y_COEFFS[idx_q],
                              QUANT_BITS);
          if (idx_q == IW'(FB_TAP_COUNT - 1)) begin
            idx_d   = '0;
            state_d = WRITE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        WRITE: begin
          od_d[gnt_q] = acc_q;
          ov_d[gnt_q] = 1'b1;
          for (int t = FB_TAP_COUNT - 1; t > 0; t--) begin
            yh_d[gnt_q][t] = yh_q[gnt_q][t-1];
          end
          yh_d[gnt_q][0] = acc_q;
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // state and history registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      gnt_q   <= '0;
      last_q  <= CW'(NUM_CH - 1);
      xh_q    <= '{default: '0};
      yh_q    <= '{default: '0};
      ov_q    <= '0;
      od_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      xh_q    <= xh_d;
      yh_q    <= yh_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
    end
  end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Bench for the shared-MAC IIR scheduler: queue-fed
// drivers, per-channel reference filter, scenarios.
module tb_iir_channel_scheduler;

  localparam int N    = 2;
  localparam int DW   = 32;
  localparam int XC   = 178;
  localparam int YC0  = -666;
  localparam int YC1  = 0;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  logic busy;

  iir_channel_scheduler_if #(
    .NUM_CH     (N),
    .DATA_WIDTH (DW)
  ) bus ();

  iir_channel_scheduler dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int ir_bad = 0;

  int mx [N][2];
  int my [N][2];
  int pend     [N][$];
  int expq     [N][$];
  int gotq     [N][$];
  int acc_edge [N][$];
  int out_edge [N][$];

  function automatic int deq(input int a, input int b);
    longint p;
    p = longint'(a) * longint'(b);
    p = p >>> 10;
    return int'(p);
  endfunction

  function automatic int model_step(input int c, input int x);
    int y;
    mx[c][1] = mx[c][0];
    mx[c][0] = x;
    y = deq(mx[c][0], XC) + deq(mx[c][1], XC)
      + deq(my[c][0], YC0) + deq(my[c][1], YC1);
    my[c][1] = my[c][0];
    my[c][0] = y;
    return y;
  endfunction

  task automatic clear_logs();
    for (int c = 0; c < N; c++) begin
      expq[c].delete();
      gotq[c].delete();
      acc_edge[c].delete();
      out_edge[c].delete();
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < N; c++) begin
      mx[c][0] = 0; mx[c][1] = 0;
      my[c][0] = 0; my[c][1] = 0;
      pend[c].delete();
    end
    clear_logs();
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // drive queued samples, log handshakes, feed model
  initial begin
    logic [N-1:0] hi;
    logic [N-1:0] ho;
    logic [N-1:0][DW-1:0] od;
    logic rs;
    int k;
    bus.in_valid = '0;
    bus.in_data  = '0;
    forever begin
      @(negedge clock);
      k  = cyc;
      rs = reset;
      hi = bus.in_valid & bus.in_ready;
      ho = bus.out_valid & bus.out_ready;
      od = bus.out_data;
      if (!rs && (($countones(bus.in_ready) > 1) ||
          (busy && (bus.in_ready != '0))))
        ir_bad++;
      @(posedge clock);
      #1;
      if (!rs) begin
        for (int c = 0; c < N; c++) begin
          if (hi[c] && pend[c].size() > 0) begin
            expq[c].push_back(model_step(c, pend[c][0]));
            acc_edge[c].push_back(k + 1);
            void'(pend[c].pop_front());
          end
          if (ho[c]) begin
            gotq[c].push_back(int'(od[c]));
            out_edge[c].push_back(k);
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        bus.in_valid[c] = (pend[c].size() > 0);
        bus.in_data[c]  = (pend[c].size() > 0) ?
                          DW'(pend[c][0]) : '0;
      end
    end
  end

  task automatic wait_got(input int c, input int n,
                          output bit to);
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (gotq[c].size() >= n) begin
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_busy(output bit to);
    to = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (busy) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    clear_model();
    pend[1].push_back(77);
    tick(); tick();
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_in_ready got %b want 00",
               bus.in_ready);
    end
    checks++;
    if (bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL rst_out_valid got %b want 00",
               bus.out_valid);
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++;
      $display("FAIL rst_out_data got %h want 0",
               bus.out_data);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b want 0", busy);
    end
    clear_model();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_impulse();
    int vin [3];
    int vexp [3];
    bit to;
    int lat;
    vin  = '{1024, 0, 0};
    vexp = '{178, 62, -41};
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      pend[0].push_back(vin[i]);
      wait_got(0, i + 1, to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL impulse_%0d timeout", i);
      end else if (gotq[0][i] !== vexp[i]) begin
        errors++;
        $display("FAIL impulse_%0d got %0d want %0d",
                 i, gotq[0][i], vexp[i]);
      end
      checks++;
      lat = to ? -1 : out_edge[0][i] - acc_edge[0][i];
      if (lat !== 5) begin
        errors++;
        $display("FAIL impulse_lat_%0d got %0d want 5",
                 i, lat);
      end
    end
  endtask

  task automatic test_two_channels();
    bit to0, to1;
    int r;
    reset = 1'b1;
    clear_model();
    pend[0].push_back(1024);
    pend[1].push_back(1024);
    tick(); tick();
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_valid_in_ready got %b want 00",
               bus.in_ready);
    end
    tick();
    reset = 1'b0;
    wait_got(0, 1, to0);
    wait_got(1, 1, to1);
    checks++;
    if (to0 || to1) begin
      errors++;
      $display("FAIL both_timeout got %0d%0d want 00",
               to0, to1);
    end else begin
      checks++;
      if (gotq[0][0] !== 178 || gotq[1][0] !== 178) begin
        errors++;
        $display("FAIL both_data got %0d,%0d want 178",
                 gotq[0][0], gotq[1][0]);
      end
      checks++;
      if (acc_edge[1][0] - acc_edge[0][0] !== 6) begin
        errors++;
        $display("FAIL both_order got %0d want 6",
                 acc_edge[1][0] - acc_edge[0][0]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      r = int'($urandom_range(0, 20000)) - 10000;
      pend[0].push_back(r);
    end
    pend[1].push_back(0);
    wait_got(1, 2, to1);
    wait_got(0, 4, to0);
    checks++;
    if (to1 || gotq[1][1] !== 62) begin
      errors++;
      $display("FAIL ch1_indep got %0d want 62",
               to1 ? -9999 : gotq[1][1]);
    end
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (to0 || gotq[0][i] !== expq[0][i]) begin
        errors++;
        $display("FAIL ch0_rand_%0d got %0d want %0d", i,
                 to0 ? -9999 : gotq[0][i], expq[0][i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int leak;
    bit done;
    bit to;
    leak = 0;
    done = 1'b0;
    clear_logs();
    bus.out_ready[0] = 1'b0;
    pend[0].push_back(int'($urandom_range(0, 4000)));
    pend[0].push_back(-321);
    pend[1].push_back(int'($urandom_range(0, 4000)));
    pend[1].push_back(555);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (bus.in_ready[0] && bus.out_valid[0]) leak++;
      tick();
      if (gotq[1].size() == 2) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done || leak !== 0) begin
      errors++;
      $display("FAIL bp_ch1 done %0d leak %0d want 1 0",
               done, leak);
    end
    checks++;
    if (pend[0].size() !== 1 || bus.out_valid[0] !== 1) begin
      errors++;
      $display("FAIL bp_hold pend %0d ov %b want 1 1",
               pend[0].size(), bus.out_valid[0]);
    end
    bus.out_ready[0] = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.in_ready[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_same_cycle got %b want 0",
               bus.in_ready[0]);
    end
    @(negedge clock);
    checks++;
    if (bus.in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_resume got %b want 1",
               bus.in_ready[0]);
    end
    wait_got(0, 2, to);
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (to || gotq[c][i] !== expq[c][i]) begin
          errors++;
          $display("FAIL bp_data_%0d_%0d got %0d want %0d",
                   c, i, to ? -9999 : gotq[c][i],
                   expq[c][i]);
        end
      end
    end
  endtask

  task automatic test_negative();
    bit to;
    do_flush();
    pend[1].push_back(-1024);
    wait_got(1, 1, to);
    checks++;
    if (to || gotq[1][0] !== -178) begin
      errors++;
      $display("FAIL negative got %0d want -178",
               to ? -9999 : gotq[1][0]);
    end
  endtask

  task automatic test_flush_mac_y();
    bit to;
    int seen;
    seen = 0;
    clear_logs();
    pend[0].push_back(1024);
    wait_busy(to);
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_model();
    @(negedge clock);
    checks++;
    if (to || busy !== 1'b0 || bus.out_valid !== 2'b00) begin
      errors++;
      $display("FAIL flush_idle busy %b ov %b want 0 00",
               busy, bus.out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (bus.out_valid != '0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL flush_no_out got %0d want 0", seen);
    end
    tick();
    pend[0].push_back(1024);
    wait_got(0, 1, to);
    checks++;
    if (to || gotq[0][0] !== 178) begin
      errors++;
      $display("FAIL flush_after got %0d want 178",
               to ? -9999 : gotq[0][0]);
    end
  endtask

  task automatic test_reset_mid();
    bit to, to0, to1;
    clear_logs();
    pend[1].push_back(1234);
    wait_busy(to);
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (to || busy !== 1'b0 || bus.out_valid !== 2'b00 ||
        bus.out_data !== '0 || bus.in_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_mid busy %b ov %b od %h want 0",
               busy, bus.out_valid, bus.out_data);
    end
    clear_model();
    pend[0].push_back(1024);
    pend[1].push_back(1024);
    tick(); tick();
    reset = 1'b0;
    wait_got(0, 1, to0);
    wait_got(1, 1, to1);
    checks++;
    if (to0 || to1) begin
      errors++;
      $display("FAIL rst_mid_timeout got %0d%0d want 00",
               to0, to1);
    end else if (acc_edge[0][0] >= acc_edge[1][0] ||
                 gotq[0][0] !== 178 ||
                 gotq[1][0] !== 178) begin
      errors++;
      $display("FAIL rst_mid_order got %0d/%0d %0d/%0d",
               acc_edge[0][0], gotq[0][0],
               acc_edge[1][0], gotq[1][0]);
    end
  endtask

  task automatic test_random();
    bit done;
    int v;
    done = 1'b0;
    clear_logs();
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < 16; i++) begin
        if ($urandom_range(0, 3) == 0) v = int'($urandom);
        else v = int'($urandom_range(0, 20000)) - 10000;
        pend[c].push_back(v);
      end
    end
    for (int i = 0; i < 3000; i++) begin
      bus.out_ready = 2'($urandom_range(0, 3));
      tick();
      if (gotq[0].size() == 16 && gotq[1].size() == 16) begin
        done = 1'b1;
        break;
      end
    end
    bus.out_ready = '1;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL rand_timeout got %0d,%0d want 16",
               gotq[0].size(), gotq[1].size());
    end else begin
      for (int c = 0; c < N; c++) begin
        for (int i = 0; i < 16; i++) begin
          checks++;
          if (gotq[c][i] !== expq[c][i]) begin
            errors++;
            $display("FAIL rand_%0d_%0d got %0d want %0d",
                     c, i, gotq[c][i], expq[c][i]);
          end
        end
      end
    end
    checks++;
    if (ir_bad !== 0) begin
      errors++;
      $display("FAIL in_ready_rule got %0d want 0", ir_bad);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    bus.out_ready = '1;
    #1;
    test_reset();
    test_impulse();
    test_two_channels();
    test_backpressure();
    test_negative();
    test_flush_mac_y();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
